// File: rtl/buzzer_tone_seq_if.sv
// Request/status bundle between the game control logic and the buzzer sequencer.
// Master drives the tone requests; slave (the sequencer) returns pin and status.
interface buzzer_tone_seq_if #(
    parameter int N_TONES = 2
);
    localparam int AT_W = (N_TONES > 1) ? $clog2(N_TONES) : 1;

    logic [N_TONES-1:0] Tone_Req;
    logic               Burst_En;
    logic               Buzzer_Out;
    logic [AT_W-1:0]    Active_Tone;
    logic               Busy;
    logic               Done;

    modport master (
        output Tone_Req, Burst_En,
        input  Buzzer_Out, Active_Tone, Busy, Done
    );

    modport slave (
        input  Tone_Req, Burst_En,
        output Buzzer_Out, Active_Tone, Busy, Done
    );
endinterface

// File: rtl/buzzer_tone_seq.sv
// Prioritised multi-channel square-wave buzzer driver with optional on/off burst gating.
// The pin is active-low; every silent state drives IDLE_LEVEL.
module buzzer_tone_seq #(
    parameter int                       N_TONES      = 2,
    parameter int                       DIV_W        = 23,
    parameter logic [N_TONES*DIV_W-1:0] HALF_PERIODS = {23'd50607, 23'd95419},
    parameter int                       DUR_W        = 26,
    parameter logic [DUR_W-1:0]         ON_CYCLES    = 26'd25000000,
    parameter logic [DUR_W-1:0]         OFF_CYCLES   = 26'd25000000,
    parameter logic [3:0]               BURST_N      = 4'd3,
    parameter logic                     IDLE_LEVEL   = 1'b1
) (
    input  logic              CLK,
    input  logic              RSTn,
    buzzer_tone_seq_if.slave  bus
);
    localparam int AT_W = (N_TONES > 1) ? $clog2(N_TONES) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_TONE_ON  = 2'd1,
        S_TONE_OFF = 2'd2,
        S_HOLD     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_TONES-1:0] r_req_q;
    logic [AT_W-1:0]    r_active;
    logic               r_burst;
    logic [DIV_W-1:0]   r_div;
    logic [DUR_W-1:0]   r_dur;
    logic [3:0]         r_beeps;
    logic               r_out;
    logic               r_busy;
    logic               r_done;

    logic [AT_W-1:0]    w_active_nxt;
    logic               w_burst_nxt;
    logic [DIV_W-1:0]   w_div_nxt;
    logic [DUR_W-1:0]   w_dur_nxt;
    logic [3:0]         w_beeps_nxt;
    logic               w_out_nxt;
    logic               w_done_nxt;

    logic [AT_W-1:0]    w_winner;
    logic               w_any;
    logic [DIV_W-1:0]   w_hp;
    logic               w_div_end;
    logic               w_on_end;
    logic               w_off_end;
    logic               w_last_beep;
    logic               w_preempt;

    // Request capture register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_req_q <= '0;
        end else begin
            r_req_q <= bus.Tone_Req;
        end
    end

    // Priority encoder: lowest set index of the captured requests wins
    always_comb begin
        w_winner = '0;
        for (int i = N_TONES - 1; i >= 0; i--) begin
            w_winner = r_req_q[i] ? AT_W'(i) : w_winner;
        end
    end

    assign w_any       = |r_req_q;
    assign w_hp        = HALF_PERIODS[int'(r_active)*DIV_W +: DIV_W];
    assign w_div_end   = (r_div == w_hp);
    assign w_on_end    = r_burst && (r_dur == (ON_CYCLES - DUR_W'(1)));
    assign w_off_end   = (r_dur == (OFF_CYCLES - DUR_W'(1)));
    assign w_last_beep = ((r_beeps + 4'd1) == BURST_N);
    assign w_preempt   = (w_winner != r_active);

    // FSM state register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic: release beats preemption, preemption beats phase end
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = w_any ? S_TONE_ON : S_IDLE;
            end
            S_TONE_ON: begin
                if (!w_any) begin
                    w_state_nxt = S_IDLE;
                end else if (w_preempt) begin
                    w_state_nxt = S_TONE_ON;
                end else if (w_on_end) begin
                    w_state_nxt = w_last_beep ? S_HOLD : S_TONE_OFF;
                end else begin
                    w_state_nxt = S_TONE_ON;
                end
            end
            S_TONE_OFF: begin
                if (!w_any) begin
                    w_state_nxt = S_IDLE;
                end else if (w_preempt || w_off_end) begin
                    w_state_nxt = S_TONE_ON;
                end else begin
                    w_state_nxt = S_TONE_OFF;
                end
            end
            S_HOLD: begin
                w_state_nxt = w_any ? S_HOLD : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM output/datapath logic: counters and pin default to cleared/idle every cycle
    always_comb begin
        w_active_nxt = r_active;
        w_burst_nxt  = r_burst;
        w_div_nxt    = '0;
        w_dur_nxt    = '0;
        w_beeps_nxt  = r_beeps;
        w_out_nxt    = IDLE_LEVEL;
        w_done_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_active_nxt = w_winner;
                    w_burst_nxt  = bus.Burst_En;
                    w_beeps_nxt  = 4'd0;
                end else begin
                    w_beeps_nxt  = r_beeps;
                end
            end
            S_TONE_ON: begin
                if (!w_any) begin
                    w_beeps_nxt = r_beeps;
                end else if (w_preempt) begin
                    w_active_nxt = w_winner;
                    w_burst_nxt  = bus.Burst_En;
                    w_beeps_nxt  = 4'd0;
                end else if (w_on_end) begin
                    w_beeps_nxt = r_beeps + 4'd1;
                    w_done_nxt  = w_last_beep;
                end else begin
                    w_div_nxt = w_div_end ? '0 : (r_div + DIV_W'(1));
                    w_out_nxt = w_div_end ? ~r_out : r_out;
                    w_dur_nxt = r_burst ? (r_dur + DUR_W'(1)) : '0;
                end
            end
            S_TONE_OFF: begin
                if (!w_any) begin
                    w_beeps_nxt = r_beeps;
                end else if (w_preempt) begin
                    w_active_nxt = w_winner;
                    w_burst_nxt  = bus.Burst_En;
                    w_beeps_nxt  = 4'd0;
                end else if (w_off_end) begin
                    w_dur_nxt = '0;
                end else begin
                    w_dur_nxt = r_dur + DUR_W'(1);
                end
            end
            S_HOLD: begin
                w_beeps_nxt = r_beeps;
            end
            default: begin
                w_beeps_nxt = 4'd0;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_active <= '0;
            r_burst  <= 1'b0;
            r_div    <= '0;
            r_dur    <= '0;
            r_beeps  <= 4'd0;
            r_out    <= IDLE_LEVEL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_active <= w_active_nxt;
            r_burst  <= w_burst_nxt;
            r_div    <= w_div_nxt;
            r_dur    <= w_dur_nxt;
            r_beeps  <= w_beeps_nxt;
            r_out    <= w_out_nxt;
            r_busy   <= (w_state_nxt != S_IDLE);
            r_done   <= w_done_nxt;
        end
    end

    assign bus.Buzzer_Out  = r_out;
    assign bus.Active_Tone = r_active;
    assign bus.Busy        = r_busy;
    assign bus.Done        = r_done;
endmodule

// File: doc/buzzer_tone_seq.md
Name: buzzer_tone_seq

Overview:
Multi-channel buzzer driver. N prioritised tone requests each select a parametrised half-period, and a square wave is produced on a single buzzer pin. An optional burst mode gates the tone into a fixed number of on/off beeps. The block sits between the game/quiz control logic (answer, time-over, alarm events) and the board buzzer pin. The pin is active-low, so it idles high.

Parameters:
N_TONES, 2, number of request channels; channel 0 has highest priority.
DIV_W, 23, width of the tone divider counter.
HALF_PERIODS, {23'd50607, 23'd95419}, packed N_TONES*DIV_W vector. Tone k half-period is bits [k*DIV_W +: DIV_W]. Here channel 0 = 95419 and channel 1 = 50607.
DUR_W, 26, width of the burst on/off duration counter.
ON_CYCLES, 26'd25000000, burst on-phase length in clocks (1..2^DUR_W-1).
OFF_CYCLES, 26'd25000000, burst off-phase length in clocks (1..2^DUR_W-1).
BURST_N, 4'd3, number of beeps per burst (1..15).
IDLE_LEVEL, 1'b1, buzzer pin level when silent.

Ports:
CLK  input  1  system clock
RSTn  input  1  reset; asynchronous, active-low
Tone_Req  input  N_TONES  level requests, one per channel
Burst_En  input  1  1 = burst mode, 0 = continuous; sampled when a tone starts
Buzzer_Out  output  1  buzzer pin
Active_Tone  output  clog2(N_TONES) (min 1)  index of the tone currently served
Busy  output  1  high in TONE_ON, TONE_OFF or HOLD
Done  output  1  one-cycle pulse when a burst completes

Behaviour:
- Reset (RSTn low, asynchronous): state IDLE; Buzzer_Out=IDLE_LEVEL, Active_Tone=0, Busy=0, Done=0. All counters and the request register are cleared.
- Request register: Tone_Req is registered each clock into req_q. The winner is the lowest set index of req_q.
- States:
  - IDLE: output IDLE_LEVEL. If req_q is nonzero, load the winner into Active_Tone, latch Burst_En, clear counters, go to TONE_ON.
  - TONE_ON:
    - Divider div counts 0..HP[Active_Tone]. At HP it wraps to 0 and Buzzer_Out toggles. Half-period = HP+1 clocks; full period = 2*(HP+1).
    - On entry the output starts at IDLE_LEVEL.
    - In burst mode, dur counts 0..ON_CYCLES-1. At the last count: beep count +1. If beep count reaches BURST_N, go to HOLD and pulse Done; otherwise go to TONE_OFF. Either way clear div and dur.
  - TONE_OFF: output IDLE_LEVEL and div held at 0. dur counts 0..OFF_CYCLES-1, then go to TONE_ON.
  - HOLD: output IDLE_LEVEL and Busy=1. Stay here until req_q is all zero, then go to IDLE. No retrigger while any request is held.
- Latency:
  - Tone_Req rising at edge E0 is captured in req_q at E0. The state becomes TONE_ON and Busy=1 at E1.
  - The first toggle occurs at edge E1+HP+1.
- Priority and preemption:
  - In TONE_ON or TONE_OFF, if the winner differs from Active_Tone, at the next edge: load the new index, re-latch Burst_En, clear div, dur and beep count, force output to IDLE_LEVEL, state TONE_ON.
  - Lower-priority requests arriving during a higher tone are ignored.
  - In HOLD, winner changes are ignored.
- Release: in TONE_ON or TONE_OFF, req_q all zero causes IDLE at the next edge. The output returns to IDLE_LEVEL at the same time, even mid-half-period or mid-burst, and Done does not pulse.
- Simultaneous events: if a release and a burst end land on the same cycle, the release wins (go to IDLE, no Done). If a preemption and a phase end land on the same cycle, the preemption wins.
- Burst_En changes while a tone is playing have no effect until the next tone start.
- Counters never exceed their terminal value, and there is no arithmetic overflow.
- HP=0 is legal and toggles the output every clock.

Test Plan:
Use overrides N_TONES=2, HALF_PERIODS = tone0 HP=4, tone1 HP=2, ON_CYCLES=20, OFF_CYCLES=10, BURST_N=2.
- Reset: RSTn low mid-tone -> Buzzer_Out=1, Busy=0, Done=0, Active_Tone=0 immediately; stays so after release with Tone_Req=0.
- Continuous: Tone_Req=2'b10, Burst_En=0 -> Busy at E1, Active_Tone=1; Buzzer_Out toggles every 3 clocks (period 6), first toggle at E1+3.
- Preemption: tone 1 playing, assert bit 0 -> one edge later Active_Tone=0, output=1, then toggles every 5 clocks; dropping bit 0 (bit 1 still set) -> returns to tone 1 and restarts.
- Burst: Tone_Req=2'b01, Burst_En=1 held -> sequence of 20 clocks toggling, 10 clocks high, 20 clocks toggling; then Done pulses for 1 cycle, output high, Busy=1 until Tone_Req=0, then Busy=0.
- Release mid-burst: drop Tone_Req during the 2nd on-phase -> IDLE next edge, output=1, Done never pulses; re-request starts a fresh burst of 2 beeps.
- Release and burst end on the same cycle -> state IDLE, Done=0.
